// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace buffer: FSM state encoding and the
// packed trace-entry layout {dest, branch, alu, instr, pc} (pc at bit 0).
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam int BRANCH_W = 1;
    localparam int OFF_PC   = 0;

    function automatic int off_instr(input int dw);
        return dw;
    endfunction

    function automatic int off_alu(input int dw);
        return 2 * dw;
    endfunction

    function automatic int off_branch(input int dw);
        return 3 * dw;
    endfunction

    function automatic int off_dest(input int dw);
        return 3 * dw + BRANCH_W;
    endfunction

    function automatic int entry_w(input int dw, input int rw);
        return 3 * dw + BRANCH_W + rw;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace storage: one synchronous write port, one asynchronous (show-ahead) read port.
module trace_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 102
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Retired-instruction trace buffer. Define TRACE_TRIGGER_EN to wait in ARMED
// for pc_in==trig_pc before capturing; otherwise arm starts capture directly.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int RA_W   = 5
) (
    input  logic                       globalclock,
    input  logic                       globalreset,
    input  logic                       valid_in,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]          instr_in,
    input  logic [DATA_W-1:0]          alu_result_in,
    input  logic                       branch_taken_in,
    input  logic [RA_W-1:0]            dest_in,
    input  logic                       arm,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]          rd_instr,
    output logic [DATA_W-1:0]          rd_alu,
    output logic                       rd_branch,
    output logic [RA_W-1:0]            rd_dest,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int EW     = entry_w(DATA_W, RA_W);
    localparam int O_INS  = off_instr(DATA_W);
    localparam int O_ALU  = off_alu(DATA_W);
    localparam int O_BR   = off_branch(DATA_W);
    localparam int O_DEST = off_dest(DATA_W);

    trace_state_e  st;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cap_cnt;
    logic          ovf;
    logic [EW-1:0] wdata, rdata;
    logic          hit, cap, pop, full, wr, drop;

`ifdef TRACE_TRIGGER_EN
    assign hit = (st == ST_ARMED) && valid_in && (pc_in == trig_pc);
`else
    logic unused_trig;
    assign unused_trig = ^trig_pc;
    assign hit = 1'b0;
`endif

    // arm wins over everything: a same-cycle capture or pop is discarded
    assign cap  = valid_in && (st == ST_CAPTURE || hit) && !arm;
    assign pop  = (cnt != '0) && rd_ready && !arm;
    assign full = (cnt == CW'(DEPTH));
    assign wr   = cap && (!full || pop);
    assign drop = cap && full && !pop;

    assign wdata = {dest_in, branch_taken_in, alu_result_in, instr_in, pc_in};

    trace_fifo_mem #(.DEPTH(DEPTH), .WIDTH(EW)) u_mem (
        .clk   (globalclock),
        .we    (wr),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge globalclock or negedge globalreset) begin
        if (!globalreset) begin
            st      <= ST_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            cap_cnt <= '0;
            ovf     <= 1'b0;
        end else if (arm) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            cap_cnt <= '0;
            ovf     <= 1'b0;
`ifdef TRACE_TRIGGER_EN
            st      <= ST_ARMED;
`else
            st      <= ST_CAPTURE;
`endif
        end else begin
            // pointers wrap by natural overflow since DEPTH is a power of two
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !wr) cnt <= cnt - 1'b1;
            if (drop) ovf <= 1'b1;
            if (cap) begin
                cap_cnt <= cap_cnt + 1'b1;
                st      <= (cap_cnt == CW'(DEPTH - 1)) ? ST_DONE : ST_CAPTURE;
            end
        end
    end

    assign rd_valid  = (cnt != '0);
    assign rd_pc     = rd_valid ? rdata[OFF_PC +: DATA_W] : '0;
    assign rd_instr  = rd_valid ? rdata[O_INS  +: DATA_W] : '0;
    assign rd_alu    = rd_valid ? rdata[O_ALU  +: DATA_W] : '0;
    assign rd_branch = rd_valid ? rdata[O_BR] : 1'b0;
    assign rd_dest   = rd_valid ? rdata[O_DEST +: RA_W] : '0;
    assign state     = st;
    assign count     = cnt;
    assign overflow  = ovf;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Randomized bench for cpu_trace_buffer against a queue-based model of the
// trace rules, plus directed scenarios with literal expectations.
module tb_cpu_trace_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int RA_W   = 5;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              globalclock = 1'b0;
    logic              globalreset = 1'b0;
    logic              valid_in = 1'b0, branch_taken_in = 1'b0, arm = 1'b0, rd_ready = 1'b0;
    logic [DATA_W-1:0] pc_in = '0, instr_in = '0, alu_result_in = '0, trig_pc = '0;
    logic [RA_W-1:0]   dest_in = '0;
    logic              rd_valid, rd_branch, overflow;
    logic [DATA_W-1:0] rd_pc, rd_instr, rd_alu;
    logic [RA_W-1:0]   rd_dest;
    logic [1:0]        state;
    logic [CW-1:0]     count;

    cpu_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RA_W(RA_W)) dut (
        .globalclock(globalclock), .globalreset(globalreset), .valid_in(valid_in),
        .pc_in(pc_in), .instr_in(instr_in), .alu_result_in(alu_result_in),
        .branch_taken_in(branch_taken_in), .dest_in(dest_in), .arm(arm),
        .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_instr(rd_instr), .rd_alu(rd_alu), .rd_branch(rd_branch), .rd_dest(rd_dest),
        .state(state), .count(count), .overflow(overflow)
    );

    always #5 globalclock = ~globalclock;

    typedef struct {
        logic [DATA_W-1:0] pc, instr, alu;
        logic              br;
        logic [RA_W-1:0]   dest;
    } ent_t;

    ent_t mq[$];
    int   m_state = 0, m_cap = 0;
    bit   m_ovf = 1'b0;
    bit   chk_on = 1'b0;
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_state = 0;
        m_cap   = 0;
        m_ovf   = 1'b0;
    endtask

    // Next-state of the trace buffer from the inputs present at the clock edge.
    task automatic model_update();
        ent_t e;
        bit hit, cap, pop;
        if (!globalreset) begin
            model_clear();
            return;
        end
        if (arm) begin
            mq.delete();
            m_cap = 0;
            m_ovf = 1'b0;
`ifdef TRACE_TRIGGER_EN
            m_state = 1;
`else
            m_state = 2;
`endif
            return;
        end
`ifdef TRACE_TRIGGER_EN
        hit = (m_state == 1) && valid_in && (pc_in == trig_pc);
`else
        hit = 1'b0;
`endif
        cap = valid_in && (m_state == 2 || hit);
        pop = (mq.size() != 0) && rd_ready;
        if (pop) void'(mq.pop_front());
        if (cap) begin
            e.pc = pc_in; e.instr = instr_in; e.alu = alu_result_in;
            e.br = branch_taken_in; e.dest = dest_in;
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1'b1;
            m_cap++;
            m_state = (m_cap == DEPTH) ? 3 : 2;
        end
    endtask

    always @(negedge globalclock) begin
        ent_t h;
        bit   v;
        if (chk_on) begin
            v = (mq.size() != 0);
            if (v) h = mq[0];
            else begin
                h.pc = '0; h.instr = '0; h.alu = '0; h.br = 1'b0; h.dest = '0;
            end
            chk("state",     32'(state),     32'(m_state));
            chk("count",     32'(count),     32'(mq.size()));
            chk("overflow",  32'(overflow),  32'(m_ovf));
            chk("rd_valid",  32'(rd_valid),  32'(v));
            chk("rd_pc",     rd_pc,          h.pc);
            chk("rd_instr",  rd_instr,       h.instr);
            chk("rd_alu",    rd_alu,         h.alu);
            chk("rd_branch", 32'(rd_branch), 32'(h.br));
            chk("rd_dest",   32'(rd_dest),   32'(h.dest));
        end
    end

    task automatic tick();
        @(posedge globalclock);
        model_update();
        #1;
    endtask

    task automatic set_instr(input logic [DATA_W-1:0] pc);
        pc_in           = pc;
        instr_in        = $urandom;
        alu_result_in   = $urandom;
        branch_taken_in = 1'($urandom_range(0, 1));
        dest_in         = RA_W'($urandom_range(0, 31));
    endtask

    initial begin
        model_clear();
        tick();
        tick();
        globalreset = 1'b1;
        chk_on = 1'b1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        tick();

`ifdef TRACE_TRIGGER_EN
        arm = 1'b1; trig_pc = 32'h40; rd_ready = 1'b0; valid_in = 1'b0;
        tick();
        arm = 1'b0;
        chk("armed_state", 32'(state), 32'd1);
        for (int k = 0; k < 32; k++) begin
            valid_in = 1'b1;
            set_instr(32'(k * 4));
            tick();
            if (state == 2'd3) break;
        end
        valid_in = 1'b0;
        chk("trig_done_state", 32'(state), 32'd3);
        chk("trig_count", 32'(count), 32'(DEPTH));
        chk("trig_first_pc", rd_pc, 32'h40);
        chk("trig_overflow", 32'(overflow), 32'd0);
        tick();
`else
        // arm with an instruction in the arm cycle: that one is discarded
        arm = 1'b1; valid_in = 1'b1; rd_ready = 1'b0;
        set_instr(32'h100);
        tick();
        arm = 1'b0;
        chk("arm_to_capture", 32'(state), 32'd2);
        chk("arm_count", 32'(count), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            set_instr(32'(32'h100 + 4 * i));
            tick();
        end
        valid_in = 1'b0;
        chk("done_state", 32'(state), 32'd3);
        chk("done_count", 32'(count), 32'(DEPTH));
        chk("first_pc", rd_pc, 32'h104);
        chk("done_overflow", 32'(overflow), 32'd0);
        tick();

        // re-arm with a full buffer: stale entries flushed
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_rd_pc", rd_pc, 32'd0);
        valid_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_instr(32'(32'h200 + 4 * i));
            tick();
        end
        valid_in = 1'b0;
        chk("refill_count", 32'(count), 32'(DEPTH));
        chk("refill_first_pc", rd_pc, 32'h200);

        // continuous drain: each entry leaves the cycle after it arrives
        arm = 1'b1; rd_ready = 1'b1;
        tick();
        arm = 1'b0; valid_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_instr(32'(32'h300 + 4 * i));
            tick();
            chk("drain_count", 32'(count), 32'd1);
            chk("drain_pc", rd_pc, 32'(32'h300 + 4 * i));
        end
        valid_in = 1'b0;
        chk("drain_done", 32'(state), 32'd3);
        tick();
        chk("drain_empty", 32'(count), 32'd0);

        // asynchronous reset in the middle of a capture
        arm = 1'b1; rd_ready = 1'b0;
        tick();
        arm = 1'b0; valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(32'(32'h400 + 4 * i));
            tick();
        end
        chk("pre_reset_count", 32'(count), 32'd3);
        #2;
        globalreset = 1'b0;
        model_clear();
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_rst_rd_pc", rd_pc, 32'd0);
        tick();
        valid_in = 1'b0;
        globalreset = 1'b1;
        tick();
`endif

        trig_pc = 32'h20;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0 && globalreset) begin
                globalreset = 1'b0;
                model_clear();
            end else begin
                globalreset = 1'b1;
            end
            arm      = ($urandom_range(0, 11) == 0);
            valid_in = ($urandom_range(0, 9) < 7);
            rd_ready = ($urandom_range(0, 9) < 3);
            set_instr({28'($urandom_range(0, 15)), 2'b00} << 2);
            tick();
        end

        globalreset = 1'b1;
        arm = 1'b0; valid_in = 1'b0; rd_ready = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
